// File: rtl/keyboard_encode.sv
// -----------------------------------------------------------------------------
// keyboard_encode
//
// Turns a key code plus a press/release flag into a PS/2 scan-code byte
// sequence and hands the bytes, one at a time, to a PS/2 byte transmitter.
//   press   : make code only
//   release : F0, then the make code
//
// Key code map (4-bit key input, shared with the game/test controller):
//   0 key_relesed (unsupported)   5 key_1   -> 16
//   1 key_A   -> 1C               6 key_2   -> 1E
//   2 key_S   -> 1B               7 key_3   -> 26
//   3 key_D   -> 23               8 key_4   -> 25
//   4 key_W   -> 1D               9 key_esc -> 76
//   10..15 unsupported
//
// Ports
//   clk          in   system clock, all logic on posedge
//   rst_n        in   synchronous reset, active-low
//   key          in   key code (map above)
//   key_release  in   1 = break sequence (F0 + code), 0 = make
//   key_valid    in   request
//   key_ready    out  high only while idle and able to accept
//   tx_start     out  one-cycle pulse: transmitter loads tx_data
//   tx_data      out  byte to transmit, stable from tx_start to tx_done_tick
//   tx_done_tick in   one-cycle pulse from transmitter: byte finished
//   seq_done     out  one-cycle pulse: whole sequence sent
//   err          out  one-cycle pulse: unsupported key or transmit timeout
//   state_dbg    out  current FSM state (debug/observability)
//
// Handshake: a request is taken in the cycle where key_valid and key_ready are
// both high; the requester keeps key_valid (and key/key_release) steady until
// then. key_ready drops the cycle after an accept and comes back only in the
// cycle after the seq_done or timeout err pulse, so a completion pulse and a
// new accept never share a cycle.
// -----------------------------------------------------------------------------
module keyboard_encode #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       key_release,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_done_tick,
  output logic       seq_done,
  output logic       err,
  output logic [2:0] state_dbg
);

  // One counter serves both the inter-byte gap and the per-byte timeout.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_F0   = 3'd1,
    WAIT_F0    = 3'd2,
    GAP        = 3'd3,
    START_CODE = 3'd4,
    WAIT_CODE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       tx_data_d;
  logic             tx_start_d;
  logic             seq_done_d;
  logic             err_d;
  logic             timeout_d;
  logic             key_ready_d;

  // Scan-code lookup for the incoming key.
  logic [7:0] map_code;
  logic       map_ok;

  always_comb begin
    map_code = 8'h00;
    map_ok   = 1'b1;
    case (key)
      4'd1:    map_code = 8'h1C;
      4'd2:    map_code = 8'h1B;
      4'd3:    map_code = 8'h23;
      4'd4:    map_code = 8'h1D;
      4'd5:    map_code = 8'h16;
      4'd6:    map_code = 8'h1E;
      4'd7:    map_code = 8'h26;
      4'd8:    map_code = 8'h25;
      4'd9:    map_code = 8'h76;
      default: map_ok   = 1'b0;
    endcase
  end

  // Next-state and next-output logic. Every output is registered, so the
  // *_d values here appear on the ports one cycle later.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    seq_done_d = 1'b0;
    err_d      = 1'b0;
    timeout_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (key_valid && key_ready) begin
          if (!map_ok) begin
            err_d = 1'b1;
          end else begin
            code_d     = map_code;
            tx_start_d = 1'b1;
            if (key_release) begin
              state_d   = START_F0;
              tx_data_d = BREAK_PREFIX;
            end else begin
              state_d   = START_CODE;
              tx_data_d = map_code;
            end
          end
        end
      end

      // tx_start is high during this cycle; a done tick seen now belongs to
      // an earlier byte and is deliberately ignored.
      START_F0: begin
        state_d = WAIT_F0;
        cnt_d   = '0;
      end

      // The tick is tested before the timeout so it wins a same-cycle tie.
      WAIT_F0: begin
        if (tx_done_tick) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // Stays GAP_CYCLES cycles, then launches the make code.
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d    = START_CODE;
          tx_start_d = 1'b1;
          tx_data_d  = code_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      START_CODE: begin
        state_d = WAIT_CODE;
        cnt_d   = '0;
      end

      WAIT_CODE: begin
        if (tx_done_tick) begin
          state_d    = IDLE;
          seq_done_d = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d   = IDLE;
          err_d     = 1'b1;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Ready is held low through the completion pulse of a sequence. An
    // unsupported-key err is raised from IDLE and leaves ready up.
    key_ready_d = (state_d == IDLE) && !seq_done_d && !timeout_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      code_q    <= 8'h00;
      key_ready <= 1'b1;
      tx_start  <= 1'b0;
      tx_data   <= 8'h00;
      seq_done  <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      key_ready <= key_ready_d;
      tx_start  <= tx_start_d;
      tx_data   <= tx_data_d;
      seq_done  <= seq_done_d;
      err       <= err_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_keyboard_encode.sv
// -----------------------------------------------------------------------------
// tb_keyboard_encode
//
// Self-checking bench for keyboard_encode. Requests are issued at the
// transaction level; the expected byte stream comes from the key -> scan-code
// table and the press/release rule, and the expected timing from the
// documented latencies (start one cycle after accept, GAP idle cycles after
// the F0 tick, seq_done one cycle after the final tick, err after TO silent
// wait cycles). A monitor pops exp_q on every tx_start.
// -----------------------------------------------------------------------------
module tb_keyboard_encode;

  localparam int GAP = 5;
  localparam int TO  = 40;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_release = 1'b0;
  logic       key_valid = 1'b0;
  logic       tx_done_tick = 1'b0;
  logic       key_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       seq_done;
  logic       err;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  keyboard_encode #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .key_release  (key_release),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_done_tick (tx_done_tick),
    .seq_done     (seq_done),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Every transmitted byte must be the next one the model expects.
  always @(negedge clk) begin : tx_monitor
    logic [7:0] e;
    if (rst_n && tx_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected", {31'd0, tx_start}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tx_byte", {24'd0, tx_data}, {24'd0, e});
      end
    end
  end

  // Reference key table: {supported, scan code}.
  function automatic logic [8:0] ref_map(input logic [3:0] k);
    case (k)
      4'd1:    return {1'b1, 8'h1C};
      4'd2:    return {1'b1, 8'h1B};
      4'd3:    return {1'b1, 8'h23};
      4'd4:    return {1'b1, 8'h1D};
      4'd5:    return {1'b1, 8'h16};
      4'd6:    return {1'b1, 8'h1E};
      4'd7:    return {1'b1, 8'h26};
      4'd8:    return {1'b1, 8'h25};
      4'd9:    return {1'b1, 8'h76};
      default: return {1'b0, 8'h00};
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (key_ready !== 1'b1 && n < 3 * TO) begin
      step();
      n++;
    end
    check("ready_wait", {31'd0, key_ready}, 32'd1);
  endtask

  // One request. d0/to0 describe the transmitter for the first byte, d1/to1
  // for the second (break only): d = wait cycles before the tick, to = never
  // tick. early adds ignorable ticks in the start cycle and inside the gap.
  task automatic request(input logic [3:0] k, input logic rel,
                         input int d0, input int d1,
                         input bit to0, input bit to1, input bit early);
    logic [8:0] m;
    logic [7:0] bytes[2];
    int         nb;
    int         d;
    bit         to;
    bit         bad;

    m = ref_map(k);
    wait_ready();
    key         = k;
    key_release = rel;
    key_valid   = 1'b1;
    if (m[8]) exp_q.push_back(rel ? 8'hF0 : m[7:0]);
    step();
    key_valid   = 1'b0;
    key         = 4'($urandom);
    key_release = 1'($urandom);

    if (!m[8]) begin
      check("unsup_err", {31'd0, err}, 32'd1);
      check("unsup_nostart", {31'd0, tx_start}, 32'd0);
      check("unsup_ready", {31'd0, key_ready}, 32'd1);
      step();
      check("unsup_err_clr", {31'd0, err}, 32'd0);
      return;
    end

    nb       = rel ? 2 : 1;
    bytes[0] = rel ? 8'hF0 : m[7:0];
    bytes[1] = m[7:0];

    for (int i = 0; i < nb; i++) begin
      d  = (i == 0) ? d0 : d1;
      to = (i == 0) ? to0 : to1;
      check("start_pulse", {31'd0, tx_start}, 32'd1);
      check("ready_busy", {31'd0, key_ready}, 32'd0);
      tx_done_tick = early;
      step();
      tx_done_tick = 1'b0;
      bad = 1'b0;
      if (to) begin
        for (int c = 0; c < TO; c++) begin
          if (err !== 1'b0 || tx_start !== 1'b0 || seq_done !== 1'b0) bad = 1'b1;
          step();
        end
        check("to_quiet", {31'd0, bad}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_no_seq", {31'd0, seq_done}, 32'd0);
        check("to_ready_low", {31'd0, key_ready}, 32'd0);
        step();
        check("to_ready_back", {31'd0, key_ready}, 32'd1);
        check("to_err_clr", {31'd0, err}, 32'd0);
        return;
      end
      for (int c = 0; c < d; c++) begin
        if (err !== 1'b0 || tx_start !== 1'b0 || seq_done !== 1'b0) bad = 1'b1;
        step();
      end
      check("wait_quiet", {31'd0, bad}, 32'd0);
      tx_done_tick = 1'b1;
      step();
      tx_done_tick = 1'b0;
      if (i < nb - 1) begin
        bad = 1'b0;
        for (int g = 0; g < GAP; g++) begin
          if (tx_start !== 1'b0 || err !== 1'b0 || seq_done !== 1'b0) bad = 1'b1;
          tx_done_tick = early && (g == 1);
          if (g == GAP - 1) exp_q.push_back(bytes[1]);
          step();
        end
        tx_done_tick = 1'b0;
        check("gap_quiet", {31'd0, bad}, 32'd0);
      end else begin
        check("seq_done", {31'd0, seq_done}, 32'd1);
        check("seq_ready_low", {31'd0, key_ready}, 32'd0);
        check("seq_no_err", {31'd0, err}, 32'd0);
        step();
        check("seq_done_clr", {31'd0, seq_done}, 32'd0);
        check("ready_back", {31'd0, key_ready}, 32'd1);
        check("data_hold", {24'd0, tx_data}, {24'd0, bytes[i]});
      end
    end
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // Reset held two cycles.
    rst_n = 1'b0;
    step();
    step();
    check("rst_ready", {31'd0, key_ready}, 32'd1);
    check("rst_start", {31'd0, tx_start}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'h00);
    check("rst_seq", {31'd0, seq_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step();

    // Done tick while idle is ignored.
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    step();
    check("idle_tick_seq", {31'd0, seq_done}, 32'd0);
    check("idle_tick_ready", {31'd0, key_ready}, 32'd1);

    // Make key_A, tick 10 cycles later.
    request(4'd1, 1'b0, 10, 0, 1'b0, 1'b0, 1'b0);
    // Break key_W.
    request(4'd4, 1'b1, 3, 4, 1'b0, 1'b0, 1'b0);
    // Unsupported codes: key_relesed and an unused code.
    request(4'd0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    request(4'd15, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
    // Timeout on key_esc, then a normal send.
    request(4'd9, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    request(4'd9, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0);
    // Timeout on the F0 byte and on the code byte of a break.
    request(4'd3, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
    request(4'd2, 1'b1, 2, 0, 1'b0, 1'b1, 1'b0);
    // Tick in the last cycle before timeout wins.
    request(4'd5, 1'b0, TO - 1, 0, 1'b0, 1'b0, 1'b0);
    request(4'd8, 1'b1, TO - 1, TO - 1, 1'b0, 1'b0, 1'b0);
    // Ticks in start cycles and in the gap are ignored.
    request(4'd6, 1'b1, 1, 1, 1'b0, 1'b0, 1'b1);

    // Reset during the gap of a break: the code byte is never sent.
    wait_ready();
    key = 4'd7; key_release = 1'b1; key_valid = 1'b1;
    exp_q.push_back(8'hF0);
    step();
    key_valid = 1'b0;
    check("mr_start", {31'd0, tx_start}, 32'd1);
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_ready", {31'd0, key_ready}, 32'd1);
    check("mr_start_clr", {31'd0, tx_start}, 32'd0);
    check("mr_data", {24'd0, tx_data}, 32'h00);
    check("mr_seq", {31'd0, seq_done}, 32'd0);
    check("mr_err", {31'd0, err}, 32'd0);
    for (int c = 0; c < GAP + 4; c++) step();
    check("mr_no_code", exp_q.size(), 32'd0);

    // Valid held while busy is taken only after seq_done.
    wait_ready();
    key = 4'd1; key_release = 1'b0; key_valid = 1'b1;
    exp_q.push_back(8'h1C);
    step();
    check("hold_start", {31'd0, tx_start}, 32'd1);
    key = 4'd6;
    for (int c = 0; c < 4; c++) step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("hold_seq", {31'd0, seq_done}, 32'd1);
    check("hold_ready_low", {31'd0, key_ready}, 32'd0);
    exp_q.push_back(8'h1E);
    step();
    check("hold_ready", {31'd0, key_ready}, 32'd1);
    check("hold_no_start", {31'd0, tx_start}, 32'd0);
    step();
    key_valid = 1'b0;
    check("hold_start2", {31'd0, tx_start}, 32'd1);
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    check("hold_seq2", {31'd0, seq_done}, 32'd1);
    step();

    // Randomized requests.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] k;
      logic       rel;
      int         d0, d1;
      bit         t0, t1, early;
      k     = 4'($urandom_range(0, 15));
      rel   = 1'($urandom);
      d0    = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 12);
      d1    = ($urandom_range(0, 7) == 0) ? TO - 1 : $urandom_range(0, 12);
      t0    = ($urandom_range(0, 9) == 0);
      t1    = ($urandom_range(0, 9) == 0);
      early = 1'($urandom);
      request(k, rel, d0, d1, t0, t1, early);
      for (int c = 0; c < $urandom_range(0, 3); c++) begin
        tx_done_tick = 1'($urandom);
        step();
      end
      tx_done_tick = 1'b0;
    end

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
